regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-back side of the core register file: merges ALU results and variable-latency
//  load results onto the regfile's single write port (WR_addr_in/WR_data_in/wena).
//  ALU results have priority. Load results wait in a small FIFO when the port is busy.
//  A starvation counter forces periodic load drains. Sits between execute/mem and regfile.
// PARAMETERS
//  DATAPATH_WIDTH      64  width of write data
//  REGFILE_ADDR_WIDTH  5   width of register address
//  LDQ_DEPTH           4   load-result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT        8   consecutive ALU-won cycles with loads queued before a forced drain
// PORTS
//  clk          in   1                   clock, all state on posedge
//  reset        in   1                   asynchronous, active-high; clears all state
//  alu_valid    in   1                   ALU result present this cycle (no ready; accepted unless alu_stall)
//  alu_addr     in   REGFILE_ADDR_WIDTH  ALU destination register
//  alu_data     in   DATAPATH_WIDTH      ALU result
//  alu_stall    out  1                   registered; upstream must hold alu_valid=0 this cycle
//  ld_valid     in   1                   load result offered
//  ld_ready     out  1                   = !ldq_full (combinational from state only)
//  ld_addr      in   REGFILE_ADDR_WIDTH  load destination register
//  ld_data      in   DATAPATH_WIDTH      load result
//  ldq_count    out  clog2(LDQ_DEPTH)+1  current FIFO occupancy
//  wr_addr_out  out  REGFILE_ADDR_WIDTH  to regfile WR_addr_in (registered)
//  wr_data_out  out  DATAPATH_WIDTH      to regfile WR_data_in (registered)
//  wena_out     out  1                   to regfile wena (registered)
// BEHAVIOUR
//  - Reset: wena_out=0, wr_addr_out=0, wr_data_out=0, alu_stall=0, FIFO empty, ldq_count=0,
//    starve counter=0. Reset mid-operation discards queued loads, no write issued.
//  - Load handshake: transfer when ld_valid && ld_ready; ld_ready=0 iff count==LDQ_DEPTH.
//  - Per-cycle selection (priority order), result registered, write 1 cycle after accept:
//    1. alu_stall==1 and FIFO non-empty: pop FIFO head -> write port; ALU input ignored.
//    2. alu_valid: ALU -> write port; any accepted load is pushed to FIFO.
//    3. FIFO non-empty: pop head -> write port; accepted load pushed (push+pop same cycle ok).
//    4. FIFO empty and load accepted: bypass load straight to write port (not enqueued).
//    5. otherwise wena_out=0 next cycle (addr/data hold last value).
//  - Loads written strictly in acceptance order. Ordering between ALU and load for the
//    same register is guaranteed by the issue stage; arbiter does not check it.
//  - Starve counter: increments each cycle case 2 wins while FIFO non-empty; clears on
//    any pop or when FIFO empty. When it reaches STARVE_LIMIT-1 and increments, alu_stall=1
//    next cycle for exactly one cycle, counter clears. alu_stall with FIFO empty (drained
//    by other means) -> no write, alu_valid must still be 0.
//  - Push when full is impossible (ld_ready=0); pointers wrap modulo LDQ_DEPTH.
//  - ldq_count updates on posedge: +1 push only, -1 pop only, unchanged on both/neither.
// STRUCTURE
//  - Shared package: DATAPATH_WIDTH, REGFILE_ADDR_WIDTH defaults, wb source-select encoding
//    (WB_NONE, WB_ALU, WB_LDQ, WB_LDBYP).
//  - One sub-module: wb_sync_fifo (DEPTH, WIDTH=ADDR+DATA; push/pop/full/empty/count,
//    async active-high reset). Arbiter, starve counter, output regs in top.
// TESTING
//  1. Reset asserted async mid-cycle with 3 queued loads -> outputs 0 immediately, count=0,
//     no wena after release.
//  2. Lone load (ld_addr=5, ld_data=64'hA5) FIFO empty, no ALU -> next cycle wena_out=1,
//     wr_addr_out=5, wr_data_out=64'hA5; count stays 0.
//  3. alu_valid(addr=1,data=0x11) with load(addr=2,data=0x22) same cycle -> cycle+1 writes r1,
//     cycle+2 writes r2; count 1 then 0.
//  4. alu_valid held high, 5 loads offered -> 4 accepted, ld_ready=0 at count=4, 5th held;
//     alu_stall pulses after 8 ALU-won cycles, head load written that cycle.
//  5. Loads addr 3,4,5 accepted under ALU pressure -> written in order 3,4,5, never reordered.
//  6. Simultaneous push+pop at count=2 -> count stays 2, FIFO order preserved across wrap.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter: default widths
// and the write-port source-select encoding.
package regfile_wb_arbiter_pkg;

    localparam int DATAPATH_WIDTH_DFLT     = 64;
    localparam int REGFILE_ADDR_WIDTH_DFLT = 5;

    typedef enum logic [1:0] {
        WB_NONE  = 2'd0,
        WB_ALU   = 2'd1,
        WB_LDQ   = 2'd2,
        WB_LDBYP = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Execute/mem-side handshake and regfile write-port bundle of the write-back arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATAPATH_WIDTH     = DATAPATH_WIDTH_DFLT,
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DFLT,
    parameter int LDQ_DEPTH          = 4
);
    localparam int CNT_W = $clog2(LDQ_DEPTH) + 1;

    logic                          alu_valid;
    logic [REGFILE_ADDR_WIDTH-1:0] alu_addr;
    logic [DATAPATH_WIDTH-1:0]     alu_data;
    logic                          alu_stall;
    logic                          ld_valid;
    logic                          ld_ready;
    logic [REGFILE_ADDR_WIDTH-1:0] ld_addr;
    logic [DATAPATH_WIDTH-1:0]     ld_data;
    logic [CNT_W-1:0]              ldq_count;
    logic [REGFILE_ADDR_WIDTH-1:0] wr_addr_out;
    logic [DATAPATH_WIDTH-1:0]     wr_data_out;
    logic                          wena_out;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  alu_stall, ld_ready, ldq_count, wr_addr_out, wr_data_out, wena_out
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output alu_stall, ld_ready, ldq_count, wr_addr_out, wr_data_out, wena_out
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO holding pending load results ({addr, data}) in acceptance order.
module wb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load results onto the single regfile write port; ALU has priority,
// loads queue in a FIFO and a starvation counter forces a periodic load drain.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATAPATH_WIDTH     = DATAPATH_WIDTH_DFLT,
    parameter int REGFILE_ADDR_WIDTH = REGFILE_ADDR_WIDTH_DFLT,
    parameter int LDQ_DEPTH          = 4,
    parameter int STARVE_LIMIT       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int ENTRY_W  = REGFILE_ADDR_WIDTH + DATAPATH_WIDTH;
    localparam int CNT_W    = $clog2(LDQ_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

    logic [ENTRY_W-1:0]  head_p0;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                ld_acc_p0;
    logic                alu_win_p0;
    logic                push_p0;
    logic                pop_p0;
    logic                stall_set_p0;
    wb_sel_e             sel_p0;
    logic [STARVE_W-1:0] starve_cnt;

    assign bus.ld_ready  = !fifo_full;
    assign bus.ldq_count = fifo_count;
    assign ld_acc_p0     = bus.ld_valid && !fifo_full;
    // An ALU result offered during a forced-drain cycle is ignored outright.
    assign alu_win_p0    = bus.alu_valid && !bus.alu_stall;

    always_comb begin
        sel_p0  = WB_NONE;
        push_p0 = 1'b0;
        pop_p0  = 1'b0;
        if (bus.alu_stall && !fifo_empty) begin
            sel_p0  = WB_LDQ;
            pop_p0  = 1'b1;
            push_p0 = ld_acc_p0;
        end else if (alu_win_p0) begin
            sel_p0  = WB_ALU;
            push_p0 = ld_acc_p0;
        end else if (!fifo_empty) begin
            sel_p0  = WB_LDQ;
            pop_p0  = 1'b1;
            push_p0 = ld_acc_p0;
        end else if (ld_acc_p0) begin
            sel_p0  = WB_LDBYP;
        end
    end

    assign stall_set_p0 = (sel_p0 == WB_ALU) && !fifo_empty &&
                          (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));

    wb_sync_fifo #(
        .DEPTH (LDQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ldq (
        .clk   (clk),
        .reset (reset),
        .push  (push_p0),
        .pop   (pop_p0),
        .din   ({bus.ld_addr, bus.ld_data}),
        .dout  (head_p0),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // p0 -> p1: selected result registered onto the regfile write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wena_out    <= 1'b0;
            bus.wr_addr_out <= '0;
            bus.wr_data_out <= '0;
            bus.alu_stall   <= 1'b0;
            starve_cnt      <= '0;
        end else begin
            bus.wena_out  <= (sel_p0 != WB_NONE);
            bus.alu_stall <= stall_set_p0;
            if (sel_p0 == WB_ALU && !fifo_empty) begin
                starve_cnt <= stall_set_p0 ? '0 : starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            unique case (sel_p0)
                WB_ALU: begin
                    bus.wr_addr_out <= bus.alu_addr;
                    bus.wr_data_out <= bus.alu_data;
                end
                WB_LDQ: begin
                    {bus.wr_addr_out, bus.wr_data_out} <= head_p0;
                end
                WB_LDBYP: begin
                    bus.wr_addr_out <= bus.ld_addr;
                    bus.wr_data_out <= bus.ld_data;
                end
                default: begin
                    bus.wr_addr_out <= bus.wr_addr_out;
                    bus.wr_data_out <= bus.wr_data_out;
                end
            endcase
        end
    end

endmodule
